// File: rtl/strb_to_lanes_if.sv
// -----------------------------------------------------------------------------
// strb_to_lanes_if
//
// Stream bus for the strb_to_lanes adapter. It carries both sides of the single
// pipeline stage: the keep-mask ingress stream (s_*) and the lane-request
// egress stream (m_*) that feeds the variable-width lane FIFO write port.
//
// Signal names keep the _i/_o suffix as seen from the adapter, so the RTL and
// any surrounding integration read the same way.
//
//   s_data_i        [NumElem][ElemWidth]  input lanes
//   s_keep_i        [NumElem]             lane-valid mask, bit i qualifies lane i
//   s_last_i                              end of packet
//   s_valid_i                             input beat valid
//   s_ready_o                             input beat accepted
//   m_data_o        [NumElem][ElemWidth]  registered lanes, unmoved
//   m_start_lane_o  [$clog2(NumElem)]     lowest kept lane
//   m_num_lanes_o   [$clog2(NumElem+1)]   number of kept lanes
//   m_last_o                              end of packet
//   m_valid_o                             output beat valid
//   m_ready_i                             downstream accepts
//
// Modports:
//   slave  - the adapter itself (consumes s_*, m_ready_i; drives the rest)
//   master - the environment around it (source of s_*, sink of m_*)
// -----------------------------------------------------------------------------
interface strb_to_lanes_if #(
  parameter int ElemWidth = 8,
  parameter int NumElem   = 4
);

  localparam int StartW = $clog2(NumElem);
  localparam int NumW   = $clog2(NumElem + 1);

  logic [NumElem-1:0][ElemWidth-1:0] s_data_i;
  logic [NumElem-1:0]                s_keep_i;
  logic                              s_last_i;
  logic                              s_valid_i;
  logic                              s_ready_o;

  logic [NumElem-1:0][ElemWidth-1:0] m_data_o;
  logic [StartW-1:0]                 m_start_lane_o;
  logic [NumW-1:0]                   m_num_lanes_o;
  logic                              m_last_o;
  logic                              m_valid_o;
  logic                              m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_start_lane_o, m_num_lanes_o, m_last_o,
           m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_start_lane_o, m_num_lanes_o, m_last_o,
           m_valid_o
  );

endinterface : strb_to_lanes_if

// File: rtl/strb_to_lanes.sv
// -----------------------------------------------------------------------------
// strb_to_lanes
//
// Ingress adapter in front of the variable-width lane FIFO. Each accepted beat
// has its keep mask decoded into the (start_lane, num_lanes) form used by the
// FIFO write port and is then held in a single registered stage with full
// ready/valid backpressure.
//
// Beat classification:
//   contiguous, >=1 lane  -> forwarded with its start/num and last
//   all-zero, last        -> zero-lane terminator (start=0, num=0, last=1)
//   all-zero, not last    -> consumed, nothing emitted
//   non-contiguous        -> dropped and counted, error flag set; a last beat
//                            still emits a terminator so framing survives
//
// Ports:
//   clk_i            clock, rising edge
//   arst_i           asynchronous active-high reset
//   bus              strb_to_lanes_if.slave (s_* ingress, m_* egress)
//   err_clear_i      synchronous clear of err_noncontig_o
//   err_noncontig_o  sticky: a non-contiguous keep was accepted
//   drop_count_o     beats dropped for non-contiguous keep, saturating
//   pkt_count_o      output handshakes with last, saturating
// -----------------------------------------------------------------------------
module strb_to_lanes #(
  parameter int ElemWidth  = 8,
  parameter int NumElem    = 4,
  parameter int CountWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  strb_to_lanes_if.slave        bus,
  input  logic                  err_clear_i,
  output logic                  err_noncontig_o,
  output logic [CountWidth-1:0] drop_count_o,
  output logic [CountWidth-1:0] pkt_count_o
);

  localparam int StartW = $clog2(NumElem);
  localparam int NumW   = $clog2(NumElem + 1);

  typedef enum logic [1:0] {
    KIND_LANES, // load data with decoded start/num
    KIND_TERM,  // load a zero-lane end-of-packet terminator
    KIND_SKIP   // consume without emitting anything
  } beat_kind_e;

  // ---------------------------------------------------------------------------
  // Output stage registers
  // ---------------------------------------------------------------------------
  logic [NumElem-1:0][ElemWidth-1:0] r_data;
  logic [StartW-1:0]                 r_start;
  logic [NumW-1:0]                   r_num;
  logic                              r_last;
  logic                              r_valid;

  logic                              r_err;
  logic [CountWidth-1:0]             r_drop_count;
  logic [CountWidth-1:0]             r_pkt_count;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic w_s_ready;
  logic w_s_hs;
  logic w_m_hs;

  // The stage can take a beat when it is empty or is being drained this cycle,
  // which gives back-to-back throughput without a skid buffer.
  assign w_s_ready = ~r_valid | bus.m_ready_i;
  assign w_s_hs    = bus.s_valid_i & w_s_ready;
  assign w_m_hs    = r_valid & bus.m_ready_i;

  // ---------------------------------------------------------------------------
  // Keep decode
  // ---------------------------------------------------------------------------
  logic [StartW-1:0]  w_start;
  logic [NumW-1:0]    w_num;
  logic [NumElem-1:0] w_shifted;
  logic [NumElem:0]   w_ones;
  logic               w_contig;
  logic               w_noncontig;
  beat_kind_e         w_kind;

  // Lowest set bit and popcount. An all-zero mask yields start=0, num=0.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    logic found;
    w_start = '0;
    w_num   = '0;
    found   = 1'b0;
    for (int i = 0; i < NumElem; i++) begin
      if (bus.s_keep_i[i] && !found) begin
        w_start = StartW'(i);
        found   = 1'b1;
      end
      w_num = w_num + NumW'(bus.s_keep_i[i]);
    end
  end

  // The mask is contiguous when, shifted down to its lowest set bit, it is a
  // solid run of num ones. The run is built one bit wider than the mask so a
  // full mask (num = NumElem) does not overflow.
  assign w_shifted   = bus.s_keep_i >> w_start;
  assign w_ones      = ((NumElem+1)'(1) << w_num) - (NumElem+1)'(1);
  assign w_contig    = ({1'b0, w_shifted} == w_ones);
  assign w_noncontig = ~w_contig;

  // An all-zero mask passes the contiguity test with num=0, so it falls into
  // the terminator/skip branches together with the non-contiguous case.
  always_comb begin
    w_kind = KIND_SKIP;
    if (w_contig && (w_num != '0)) begin
      w_kind = KIND_LANES;
    end else if (bus.s_last_i) begin
      w_kind = KIND_TERM;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // races between always_ff blocks.
  // NOTE: the data register is reset along with the control bits so the output
  // bus is deterministic out of reset; it is small, so the reset cost is minor.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_data  <= '0;
      r_start <= '0;
      r_num   <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_s_hs) begin
      unique case (w_kind)
        KIND_LANES: begin
          r_data  <= bus.s_data_i;
          r_start <= w_start;
          r_num   <= w_num;
          r_last  <= bus.s_last_i;
          r_valid <= 1'b1;
        end
        KIND_TERM: begin
          r_data  <= bus.s_data_i;
          r_start <= '0;
          r_num   <= '0;
          r_last  <= 1'b1;
          r_valid <= 1'b1;
        end
        default: begin
          // Silent consume: only the drain of the held beat is visible.
          if (w_m_hs) begin
            r_valid <= 1'b0;
          end
        end
      endcase
    end else if (w_m_hs) begin
      r_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag and statistics
  // ---------------------------------------------------------------------------
  // Setting has priority over clearing so a non-contiguous beat arriving in
  // the same cycle as a clear is never lost.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_err <= 1'b0;
    end else if (w_s_hs && w_noncontig) begin
      r_err <= 1'b1;
    end else if (err_clear_i) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_drop_count <= '0;
    end else if (w_s_hs && w_noncontig && !(&r_drop_count)) begin
      r_drop_count <= r_drop_count + CountWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_pkt_count <= '0;
    end else if (w_m_hs && r_last && !(&r_pkt_count)) begin
      r_pkt_count <= r_pkt_count + CountWidth'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready_o      = w_s_ready;
  assign bus.m_data_o       = r_data;
  assign bus.m_start_lane_o = r_start;
  assign bus.m_num_lanes_o  = r_num;
  assign bus.m_last_o       = r_last;
  assign bus.m_valid_o      = r_valid;

  assign err_noncontig_o    = r_err;
  assign drop_count_o       = r_drop_count;
  assign pkt_count_o        = r_pkt_count;

endmodule : strb_to_lanes

// File: tb/tb_strb_to_lanes.sv
// -----------------------------------------------------------------------------
// tb_strb_to_lanes
//
// Directed bench for strb_to_lanes with NumElem=4, ElemWidth=8, CountWidth=4.
// Inputs change 1 ns after a rising edge; outputs are read at that point too,
// so each read reflects the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_strb_to_lanes;

  localparam int EW = 8;
  localparam int NE = 4;
  localparam int CW = 4;

  logic          clk_i;
  logic          arst_i;
  logic          err_clear_i;
  logic          err_noncontig_o;
  logic [CW-1:0] drop_count_o;
  logic [CW-1:0] pkt_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  strb_to_lanes_if #(.ElemWidth(EW), .NumElem(NE)) bus ();

  strb_to_lanes #(
    .ElemWidth (EW),
    .NumElem   (NE),
    .CountWidth(CW)
  ) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .bus            (bus),
    .err_clear_i    (err_clear_i),
    .err_noncontig_o(err_noncontig_o),
    .drop_count_o   (drop_count_o),
    .pkt_count_o    (pkt_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat for exactly one edge; the caller guarantees s_ready.
  task automatic send(input logic [31:0] data, input logic [3:0] keep,
                      input logic last);
    bus.s_data_i  = data;
    bus.s_keep_i  = keep;
    bus.s_last_i  = last;
    bus.s_valid_i = 1'b1;
    check("send_ready", 32'(bus.s_ready_o), 32'd1);
    step();
    bus.s_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] beat(input int i);
    return 32'h5A6B7C00 + 32'(i);
  endfunction

  initial begin
    logic [31:0] held;
    logic        stalled;
    logic        s_hs_now;
    int          sent;
    int          rcvd;

    arst_i        = 1'b1;
    err_clear_i   = 1'b0;
    bus.s_data_i  = '0;
    bus.s_keep_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 1'b1;

    // ---------------- reset state ----------------
    #12;
    check("rst_valid", 32'(bus.m_valid_o), 32'd0);
    check("rst_ready", 32'(bus.s_ready_o), 32'd1);
    check("rst_err",   32'(err_noncontig_o), 32'd0);
    check("rst_drop",  32'(drop_count_o), 32'd0);
    check("rst_pkt",   32'(pkt_count_o), 32'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    step();

    // ---------------- single beat ----------------
    send(32'hD3D2D1D0, 4'b0110, 1'b1);
    check("single_valid", 32'(bus.m_valid_o), 32'd1);
    check("single_start", 32'(bus.m_start_lane_o), 32'd1);
    check("single_num",   32'(bus.m_num_lanes_o), 32'd2);
    check("single_data",  32'(bus.m_data_o), 32'hD3D2D1D0);
    check("single_last",  32'(bus.m_last_o), 32'd1);
    check("single_pkt0",  32'(pkt_count_o), 32'd0);
    step();
    check("single_pkt1",  32'(pkt_count_o), 32'd1);
    check("single_drain", 32'(bus.m_valid_o), 32'd0);

    // ---------------- streaming with backpressure ----------------
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
      bus.m_ready_i = (cyc % 3 == 0);
      bus.s_valid_i = (sent < 8);
      bus.s_data_i  = beat(sent);
      bus.s_keep_i  = 4'b1111;
      bus.s_last_i  = (sent == 7);
      #1;
      if (bus.m_valid_o && bus.m_ready_i) begin
        check("strm_data",  32'(bus.m_data_o), beat(rcvd));
        check("strm_num",   32'(bus.m_num_lanes_o), 32'd4);
        check("strm_start", 32'(bus.m_start_lane_o), 32'd0);
        check("strm_last",  32'(bus.m_last_o), 32'(rcvd == 7));
        rcvd++;
      end
      stalled = bus.m_valid_o && !bus.m_ready_i;
      held    = bus.m_data_o;
      if (stalled) check("strm_stall_rdy", 32'(bus.s_ready_o), 32'd0);
      s_hs_now = bus.s_valid_i && bus.s_ready_o;
      step();
      if (s_hs_now) sent++;
      if (stalled) begin
        check("strm_hold_valid", 32'(bus.m_valid_o), 32'd1);
        check("strm_hold_data",  32'(bus.m_data_o), held);
      end
    end
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 1'b1;
    check("strm_count", 32'(rcvd), 32'd8);
    check("strm_empty", 32'(bus.m_valid_o), 32'd0);
    check("strm_pkt",   32'(pkt_count_o), 32'd2);

    // ---------------- non-contiguous ----------------
    send(32'h11111111, 4'b1010, 1'b0);
    check("nc1_valid", 32'(bus.m_valid_o), 32'd0);
    check("nc1_drop",  32'(drop_count_o), 32'd1);
    check("nc1_err",   32'(err_noncontig_o), 32'd1);
    send(32'h22222222, 4'b0101, 1'b1);
    check("nc2_valid", 32'(bus.m_valid_o), 32'd1);
    check("nc2_num",   32'(bus.m_num_lanes_o), 32'd0);
    check("nc2_start", 32'(bus.m_start_lane_o), 32'd0);
    check("nc2_last",  32'(bus.m_last_o), 32'd1);
    check("nc2_drop",  32'(drop_count_o), 32'd2);
    step();
    check("nc2_pkt",   32'(pkt_count_o), 32'd3);
    err_clear_i = 1'b1;
    step();
    err_clear_i = 1'b0;
    check("clr_err",  32'(err_noncontig_o), 32'd0);
    check("clr_drop", 32'(drop_count_o), 32'd2);
    // Clear and a new bad beat on the same edge: the flag must stay set.
    err_clear_i = 1'b1;
    send(32'h33333333, 4'b1101, 1'b0);
    err_clear_i = 1'b0;
    check("setwin_err",  32'(err_noncontig_o), 32'd1);
    check("setwin_drop", 32'(drop_count_o), 32'd3);

    // ---------------- all-zero keep ----------------
    send(32'h44444444, 4'b0000, 1'b0);
    check("z0_valid", 32'(bus.m_valid_o), 32'd0);
    check("z0_drop",  32'(drop_count_o), 32'd3);
    check("z0_pkt",   32'(pkt_count_o), 32'd3);
    send(32'h55555555, 4'b0000, 1'b1);
    check("z1_valid", 32'(bus.m_valid_o), 32'd1);
    check("z1_num",   32'(bus.m_num_lanes_o), 32'd0);
    check("z1_last",  32'(bus.m_last_o), 32'd1);
    check("z1_data",  32'(bus.m_data_o), 32'h55555555);
    step();
    check("z1_pkt",   32'(pkt_count_o), 32'd4);
    check("z1_drop",  32'(drop_count_o), 32'd3);

    // ---------------- saturation: 20 more bad beats ----------------
    bus.s_data_i  = 32'h66666666;
    bus.s_keep_i  = 4'b1001;
    bus.s_last_i  = 1'b0;
    bus.s_valid_i = 1'b1;
    for (int k = 0; k < 20; k++) step();
    bus.s_valid_i = 1'b0;
    check("sat_drop",  32'(drop_count_o), 32'd15);
    check("sat_valid", 32'(bus.m_valid_o), 32'd0);
    check("sat_pkt",   32'(pkt_count_o), 32'd4);

    // ---------------- async reset while stalled ----------------
    bus.m_ready_i = 1'b0;
    send(32'h77777777, 4'b1111, 1'b1);
    step();
    check("pre_rst_valid", 32'(bus.m_valid_o), 32'd1);
    check("pre_rst_ready", 32'(bus.s_ready_o), 32'd0);
    #2;
    arst_i = 1'b1;
    #1;
    check("arst_valid", 32'(bus.m_valid_o), 32'd0);
    check("arst_ready", 32'(bus.s_ready_o), 32'd1);
    check("arst_drop",  32'(drop_count_o), 32'd0);
    check("arst_pkt",   32'(pkt_count_o), 32'd0);
    check("arst_err",   32'(err_noncontig_o), 32'd0);
    @(negedge clk_i);
    arst_i        = 1'b0;
    bus.m_ready_i = 1'b1;
    step();
    send(32'h8899AABB, 4'b0011, 1'b1);
    check("post_valid", 32'(bus.m_valid_o), 32'd1);
    check("post_start", 32'(bus.m_start_lane_o), 32'd0);
    check("post_num",   32'(bus.m_num_lanes_o), 32'd2);
    check("post_data",  32'(bus.m_data_o), 32'h8899AABB);
    step();
    check("post_pkt",   32'(pkt_count_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_strb_to_lanes

// File: doc/strb_to_lanes.md
# strb_to_lanes

Ingress adapter placed directly upstream of the variable-width lane FIFO. It accepts stream beats carrying `NumElem` lanes plus a per-lane keep mask. It converts each mask into the `start_lane`/`num_lanes` request form that the FIFO write port consumes. Beats pass through a single registered pipeline stage with full ready/valid backpressure, and illegal keep patterns are counted and flagged.

## Interface
- `ElemWidth`, default 8: bits per lane.
- `NumElem`, default 4: lanes per beat; must be ≥2.
- `CountWidth`, default 16: width of the statistics counters.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all logic on the rising edge.
- `arst_i`  in  1  reset, asynchronous and active-high.
- `s_data_i`  in  `[NumElem][ElemWidth]`  input lanes.
- `s_keep_i`  in  `NumElem`  lane-valid mask; bit i qualifies lane i.
- `s_last_i`  in  1  end of packet.
- `s_valid_i`  in  1  input beat valid.
- `s_ready_o`  out  1  input beat accepted.
- `m_data_o`  out  `[NumElem][ElemWidth]`  registered copy of `s_data_i`, lanes unmoved.
- `m_start_lane_o`  out  `$clog2(NumElem)`  index of the lowest kept lane.
- `m_num_lanes_o`  out  `$clog2(NumElem+1)`  number of kept lanes.
- `m_last_o`  out  1  end of packet.
- `m_valid_o`  out  1  output beat valid.
- `m_ready_i`  in  1  downstream accepts.
- `err_noncontig_o`  out  1  sticky flag: a non-contiguous keep was seen.
- `err_clear_i`  in  1  synchronous clear of `err_noncontig_o`.
- `drop_count_o`  out  `CountWidth`  beats dropped for non-contiguous keep; saturating.
- `pkt_count_o`  out  `CountWidth`  packets delivered (output handshakes with last); saturating.

## Operation
- Input handshake `s_hs = s_valid_i & s_ready_o`.
- Output handshake `m_hs = m_valid_o & m_ready_i`.
- `s_ready_o = ~m_valid_o | m_ready_i`. This is combinational and allows one beat per cycle in steady state.
- Keep decode, combinational on `s_keep_i`:
  - `start` = index of the lowest set bit (0 if the mask is all zero).
  - `num` = popcount of the mask.
  - The mask is contiguous when `(s_keep_i >> start) == (1<<num)-1`.
- Classification of each accepted beat:
  - **Contiguous, num ≥ 1:** load the register with data, `start`, `num`, `s_last_i`; set `m_valid_o`.
  - **All-zero, `s_last_i`=1:** load a zero-lane terminator: `start`=0, `num`=0, last=1, data=`s_data_i`. Set `m_valid_o`.
  - **All-zero, `s_last_i`=0:** consumed silently. `m_valid_o` ← 0 if `m_hs`, otherwise unchanged. No counter changes.
  - **Non-contiguous:** dropped. Increment `drop_count_o`, saturating at all-ones. Set `err_noncontig_o`. If `s_last_i`=1, forward a zero-lane terminator as in the all-zero case so packet framing survives; otherwise treat as a silent consume.
- Output register update without `s_hs`: if `m_hs`, `m_valid_o` ← 0; otherwise hold all outputs stable.
- `pkt_count_o` increments on `m_hs & m_last_o`, saturating.
- Simultaneous `err_clear_i` and a new non-contiguous beat in the same cycle: set wins, so the flag stays 1.
- Data fields are don't-care when `m_valid_o`=0, but they must not change while `m_valid_o=1 & ~m_ready_i`.
- `m_start_lane_o + m_num_lanes_o ≤ NumElem` is guaranteed for every valid output beat.

## Timing
- Reset (`arst_i`=1, asynchronous): all registered outputs and counters are 0 and `err_noncontig_o`=0.
  - `s_ready_o` is 1 during and after reset, since `m_valid_o`=0.
- A reset asserted mid-transfer discards the held beat, with no partial output.
- Latency is 1 cycle: a beat accepted at edge N appears on `m_*` after edge N, with `m_valid_o`=1 in cycle N+1.
- Throughput is 1 beat/cycle with `m_ready_i` held high.
- Backpressure: while `m_valid_o=1 & m_ready_i=0`, `s_ready_o`=0 and the output is frozen.
- When `m_hs` and `s_hs` happen in the same cycle, the register reloads and there is no bubble.
- Counters and the error flag update on the same edge as the triggering handshake.
- `err_clear_i` takes effect on the next edge.

## Test plan
- **Single beat:** keep=4'b0110, data={D3,D2,D1,D0}, last=1, `m_ready_i`=1 → one cycle later `m_start_lane_o`=1, `m_num_lanes_o`=2, `m_data_o` unchanged, `m_last_o`=1; `pkt_count_o`=1 after the handshake.
- **Streaming with backpressure:** 8 full beats (keep=4'b1111); `m_ready_i` toggles 1,0,0,1,… → every beat delivered exactly once, in order, with `num`=4 and `start`=0; `s_ready_o`=0 during each stalled cycle; outputs stable while stalled.
- **Non-contiguous:** keep=4'b1010 without last, then 4'b0101 with last → first beat produces no output; second produces a terminator (`num`=0, last=1). `drop_count_o`=2, `err_noncontig_o`=1. Pulse `err_clear_i` → flag 0; the count stays 2.
- **All-zero keep:** keep=0 with last=0 → nothing emitted, counters unchanged. keep=0 with last=1 → terminator emitted; `pkt_count_o` increments.
- **Saturation:** with `CountWidth`=4, send 20 non-contiguous beats → `drop_count_o` stops at 15.
- **Reset:** assert `arst_i` asynchronously while `m_valid_o`=1 and stalled → `m_valid_o`, counters and flag go to 0 immediately; `s_ready_o`=1; a fresh beat after release passes with 1-cycle latency.
